// File: rtl/nop_trap_unit.sv
// -----------------------------------------------------------------------------
// nop_trap_unit
//
// Simulation helper that watches the CPU writeback stage for l.nop K traps
// (wb_insn[31:16] == 16'h1500) and turns them into side effects:
//   K=0x0001 exit        -> exit_o pulse, exit_code_o = r3, done_o set, RUN->DONE
//   K=0x0002 report      -> report_valid_o pulse, report_data_o = r3
//   K=0x0004 putc        -> r3[7:0] pushed into a character FIFO
//   K=0x0005 count reset -> retired-instruction counter cleared
// Any other K is an ordinary instruction. It also counts retired instructions
// and runs an idle watchdog. In DONE, traps, counting and the watchdog freeze
// but the character FIFO keeps draining.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   wb_insn, wb_valid, gpr3      retiring instruction, its valid, value of r3
//   exit_o, exit_code_o, done_o  exit pulse, captured r3, sticky done
//   report_valid_o, report_data_o report pulse, captured r3 (held)
//   char_valid_o, char_data_o,
//   char_ready_i                 FIFO head handshake (pop on valid & ready)
//   char_ovf_o                   sticky: a character was dropped (FIFO full)
//   insn_cnt_o                   retired instruction count (wraps)
//   hang_o                       sticky watchdog expiry
// -----------------------------------------------------------------------------
module nop_trap_unit #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WDT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_insn,
  input  logic        wb_valid,
  input  logic [31:0] gpr3,
  output logic        exit_o,
  output logic [31:0] exit_code_o,
  output logic        done_o,
  output logic        report_valid_o,
  output logic [31:0] report_data_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        char_ovf_o,
  output logic [31:0] insn_cnt_o,
  output logic        hang_o
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] WDT_LIM  = 32'(WDT_CYCLES);

  localparam logic [15:0] NOP_OPC  = 16'h1500;
  localparam logic [15:0] K_EXIT   = 16'h0001;
  localparam logic [15:0] K_REPORT = 16'h0002;
  localparam logic [15:0] K_PUTC   = 16'h0004;
  localparam logic [15:0] K_CNTRST = 16'h0005;

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  state_t      r_state;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [31:0] r_wdt;

  logic w_run;
  logic w_trap;
  logic w_exit;
  logic w_report;
  logic w_putc;
  logic w_cnt_rst;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Traps only take effect while running; DONE freezes all of them.
  assign w_run     = (r_state == ST_RUN);
  assign w_trap    = w_run && wb_valid && (wb_insn[31:16] == NOP_OPC);
  assign w_exit    = w_trap && (wb_insn[15:0] == K_EXIT);
  assign w_report  = w_trap && (wb_insn[15:0] == K_REPORT);
  assign w_putc    = w_trap && (wb_insn[15:0] == K_PUTC);
  assign w_cnt_rst = w_trap && (wb_insn[15:0] == K_CNTRST);

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = !w_empty && char_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign w_push = w_putc && (!w_full || w_pop);
  assign w_drop = w_putc && w_full && !w_pop;

  assign char_valid_o = !w_empty;
  assign char_data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: character storage has no reset; the pointers alone define which
  // entries are valid, and char_data_o is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= gpr3[7:0];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_wdt          <= '0;
      exit_o         <= 1'b0;
      exit_code_o    <= '0;
      done_o         <= 1'b0;
      report_valid_o <= 1'b0;
      report_data_o  <= '0;
      char_ovf_o     <= 1'b0;
      insn_cnt_o     <= '0;
      hang_o         <= 1'b0;
    end else begin
      exit_o         <= 1'b0;
      report_valid_o <= 1'b0;

      // FIFO draining continues in both states.
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_drop) begin
        char_ovf_o <= 1'b1;
      end

      case (r_state)
        ST_RUN: begin
          if (wb_valid) begin
            insn_cnt_o <= w_cnt_rst ? 32'd0 : insn_cnt_o + 32'd1;
          end

          if (w_exit) begin
            exit_o      <= 1'b1;
            exit_code_o <= gpr3;
            done_o      <= 1'b1;
            r_state     <= ST_DONE;
          end

          if (w_report) begin
            report_valid_o <= 1'b1;
            report_data_o  <= gpr3;
          end

          // Idle counter saturates at the limit so it never wraps back.
          if (WDT_CYCLES != 0) begin
            if (wb_valid) begin
              r_wdt <= '0;
            end else if (r_wdt != WDT_LIM) begin
              r_wdt <= r_wdt + 32'd1;
              if ((r_wdt + 32'd1) == WDT_LIM) begin
                hang_o <= 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_DONE;
        end

        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nop_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_nop_trap_unit
//
// Drives nop_trap_unit with directed scenarios and randomized traffic and
// compares every output each cycle against a transaction-level model
// (queue-based FIFO, plain counters, a done flag).
// -----------------------------------------------------------------------------
module tb_nop_trap_unit;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WDT   = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_insn;
  logic        wb_valid;
  logic [31:0] gpr3;
  logic        exit_o;
  logic [31:0] exit_code_o;
  logic        done_o;
  logic        report_valid_o;
  logic [31:0] report_data_o;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic        char_ready_i;
  logic        char_ovf_o;
  logic [31:0] insn_cnt_o;
  logic        hang_o;

  nop_trap_unit #(
    .FIFO_DEPTH(DEPTH),
    .WDT_CYCLES(WDT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_insn       (wb_insn),
    .wb_valid      (wb_valid),
    .gpr3          (gpr3),
    .exit_o        (exit_o),
    .exit_code_o   (exit_code_o),
    .done_o        (done_o),
    .report_valid_o(report_valid_o),
    .report_data_o (report_data_o),
    .char_valid_o  (char_valid_o),
    .char_data_o   (char_data_o),
    .char_ready_i  (char_ready_i),
    .char_ovf_o    (char_ovf_o),
    .insn_cnt_o    (insn_cnt_o),
    .hang_o        (hang_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit          m_done;
  logic [31:0] m_cnt;
  byte         m_q[$];
  bit          m_ovf;
  bit          m_hang;
  int          m_idle;
  bit          m_exit;
  logic [31:0] m_code;
  bit          m_rep;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_done  = 0;
    m_cnt   = '0;
    m_q.delete();
    m_ovf   = 0;
    m_hang  = 0;
    m_idle  = 0;
    m_exit  = 0;
    m_code  = '0;
    m_rep   = 0;
    m_rdata = '0;
  endtask

  task automatic model_step(input logic [31:0] insn, input logic valid,
                            input logic [31:0] g, input logic ready);
    bit pop;
    bit full;
    bit trap;
    logic [15:0] k;
    pop  = (m_q.size() != 0) && ready;
    full = (m_q.size() == DEPTH);
    m_exit = 0;
    m_rep  = 0;
    if (pop) void'(m_q.pop_front());
    if (!m_done) begin
      trap = valid && (insn[31:16] == 16'h1500);
      k    = insn[15:0];
      if (valid) m_cnt = (trap && k == 16'h0005) ? 32'd0 : m_cnt + 32'd1;
      if (valid) m_idle = 0;
      else       m_idle++;
      if (WDT != 0 && m_idle >= WDT) m_hang = 1;
      if (trap) begin
        case (k)
          16'h0001: begin m_exit = 1; m_code = g; m_done = 1; end
          16'h0002: begin m_rep = 1; m_rdata = g; end
          16'h0004: begin
            if (!full || pop) m_q.push_back(byte'(g[7:0]));
            else              m_ovf = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] exp_char;
    exp_char = (m_q.size() != 0) ? 8'(m_q[0]) : 8'h00;
    check({tag, " exit_o"},         exit_o,         m_exit);
    check({tag, " exit_code_o"},    exit_code_o,    m_code);
    check({tag, " done_o"},         done_o,         m_done);
    check({tag, " report_valid_o"}, report_valid_o, m_rep);
    check({tag, " report_data_o"},  report_data_o,  m_rdata);
    check({tag, " char_valid_o"},   char_valid_o,   m_q.size() != 0);
    check({tag, " char_data_o"},    char_data_o,    exp_char);
    check({tag, " char_ovf_o"},     char_ovf_o,     m_ovf);
    check({tag, " insn_cnt_o"},     insn_cnt_o,     m_cnt);
    check({tag, " hang_o"},         hang_o,         m_hang);
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] trap_insn(input logic [15:0] k);
    return {16'h1500, k};
  endfunction

  function automatic logic [31:0] plain_insn();
    logic [31:0] v;
    v = $urandom;
    if (v[31:16] == 16'h1500) v[31:16] = 16'h1501;
    return v;
  endfunction

  // Called at a falling edge: drive, let one rising edge happen, compare.
  task automatic cycle(input logic [31:0] insn, input logic valid,
                       input logic [31:0] g, input logic ready, input string tag);
    wb_insn      = insn;
    wb_valid     = valid;
    gpr3         = g;
    char_ready_i = ready;
    @(posedge clk);
    model_step(insn, valid, g, ready);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic assert_reset();
    rst_n        = 1'b0;
    wb_valid     = 1'b0;
    char_ready_i = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    assert_reset();
    release_reset();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n        = 1'b1;
    wb_insn      = '0;
    wb_valid     = 1'b0;
    gpr3         = '0;
    char_ready_i = 1'b0;
    #1;
    do_reset();

    // Instruction counting with a count-reset trap in between.
    for (int i = 0; i < 10; i++) cycle(plain_insn(), 1'b1, $urandom, 1'b0, "cnt");
    check("cnt after 10", insn_cnt_o, 32'd10);
    cycle(trap_insn(16'h0005), 1'b1, $urandom, 1'b0, "cntrst");
    check("cnt after nop5", insn_cnt_o, 32'd0);
    for (int i = 0; i < 3; i++) cycle(plain_insn(), 1'b1, $urandom, 1'b0, "cnt");
    check("cnt after 3", insn_cnt_o, 32'd3);

    // putc 'H','i' held, then drained in order.
    cycle(trap_insn(16'h0004), 1'b1, 32'h0000_0048, 1'b0, "putc H");
    cycle(trap_insn(16'h0004), 1'b1, 32'hFFFF_FF69, 1'b0, "putc i");
    check("hi valid", char_valid_o, 1'b1);
    check("hi head H", char_data_o, 8'h48);
    cycle(32'h0, 1'b0, 32'h0, 1'b1, "drain");
    check("hi head i", char_data_o, 8'h69);
    cycle(32'h0, 1'b0, 32'h0, 1'b1, "drain");
    check("hi empty", char_valid_o, 1'b0);

    // Fill to depth, push+pop while full, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(trap_insn(16'h0004), 1'b1, 32'h30 + 32'(i), 1'b0, "fill");
    check("full no ovf", char_ovf_o, 1'b0);
    cycle(trap_insn(16'h0004), 1'b1, 32'h41, 1'b1, "push+pop full");
    check("push+pop ovf", char_ovf_o, 1'b0);
    check("push+pop head", char_data_o, 8'h31);
    cycle(trap_insn(16'h0004), 1'b1, 32'h5A, 1'b0, "overflow");
    check("ovf set", char_ovf_o, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(32'h0, 1'b0, 32'h0, 1'b1, "drain full");
    check("drained", char_valid_o, 1'b0);

    // Watchdog: 15 idle then activity keeps it quiet; 16 idle trips it.
    do_reset();
    for (int i = 0; i < WDT - 1; i++) cycle(32'h0, 1'b0, 32'h0, 1'b0, "idle");
    check("wdt 15 idle", hang_o, 1'b0);
    cycle(plain_insn(), 1'b1, 32'h0, 1'b0, "kick");
    for (int i = 0; i < WDT - 1; i++) cycle(32'h0, 1'b0, 32'h0, 1'b0, "idle");
    check("wdt after kick", hang_o, 1'b0);
    cycle(32'h0, 1'b0, 32'h0, 1'b0, "idle16");
    check("wdt 16 idle", hang_o, 1'b1);
    for (int i = 0; i < 3; i++) cycle(plain_insn(), 1'b1, 32'h0, 1'b0, "post hang");
    check("hang sticky", hang_o, 1'b1);

    // Exit freezes traps and counting; FIFO still drains.
    do_reset();
    cycle(plain_insn(), 1'b1, 32'h0, 1'b0, "pre exit");
    cycle(trap_insn(16'h0004), 1'b1, 32'h21, 1'b0, "putc pre exit");
    cycle(trap_insn(16'h0001), 1'b1, 32'h0000_002A, 1'b0, "exit");
    check("exit pulse", exit_o, 1'b1);
    check("exit code", exit_code_o, 32'h2A);
    check("done set", done_o, 1'b1);
    cycle(trap_insn(16'h0002), 1'b1, 32'h1234_5678, 1'b0, "report in done");
    check("exit one pulse", exit_o, 1'b0);
    check("no report in done", report_valid_o, 1'b0);
    cycle(trap_insn(16'h0004), 1'b1, 32'h77, 1'b1, "putc in done");
    check("cnt frozen", insn_cnt_o, 32'd3);
    check("drained in done", char_valid_o, 1'b0);

    // Asynchronous reset with characters queued.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(trap_insn(16'h0004), 1'b1, $urandom, 1'b0, "queue");
    check("3 queued", char_valid_o, 1'b1);
    assert_reset();
    check("async rst char_valid", char_valid_o, 1'b0);
    check("async rst cnt", insn_cnt_o, 32'd0);
    release_reset();

    // Randomized traffic in blocks of differing activity.
    for (int blk = 0; blk < 4; blk++) begin
      int vpct;
      int rpct;
      vpct = (blk == 0) ? 90 : (blk == 1) ? 60 : (blk == 2) ? 25 : 5;
      rpct = (blk == 3) ? 80 : 35;
      do_reset();
      for (int c = 0; c < 600; c++) begin
        logic [31:0] insn;
        logic [15:0] k;
        int r;
        r = $urandom_range(0, 999);
        if (r < 3)        insn = trap_insn(16'h0001);
        else if (r < 100) insn = trap_insn(16'h0002);
        else if (r < 450) insn = trap_insn(16'h0004);
        else if (r < 490) insn = trap_insn(16'h0005);
        else if (r < 560) begin
          k = 16'($urandom);
          if (k == 16'h1 || k == 16'h2 || k == 16'h4 || k == 16'h5) k = 16'h3;
          insn = trap_insn(k);
        end else          insn = plain_insn();
        cycle(insn, $urandom_range(0, 99) < vpct, $urandom,
              $urandom_range(0, 99) < rpct, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nop_trap_unit.md
NOP_TRAP_UNIT -- requirements
Module: nop_trap_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FIFO_DEPTH, 8, character FIFO entries, power of two, >=2.
- WDT_CYCLES, 100000, idle cycles before hang flag; 0 disables watchdog.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_insn  in  32  instruction in CPU writeback stage.
- wb_valid  in  1  wb_insn retires this cycle.
- gpr3  in  32  value of r3 at retirement.
- exit_o  out  1  one-cycle pulse on exit trap.
- exit_code_o  out  32  r3 captured at exit.
- done_o  out  1  sticky, set with exit_o.
- report_valid_o  out  1  one-cycle pulse on report trap.
- report_data_o  out  32  r3 captured at report.
- char_valid_o  out  1  FIFO not empty.
- char_data_o  out  8  FIFO head character.
- char_ready_i  in  1  consumer accepts head.
- char_ovf_o  out  1  sticky, character dropped.
- insn_cnt_o  out  32  retired instruction count.
- hang_o  out  1  sticky watchdog expiry.

Function
REQ-003 A trap SHALL be wb_valid=1 with wb_insn[31:16]=16'h1500 (l.nop K); K=wb_insn[15:0].
REQ-004 K=0x0001 (exit): next cycle exit_o=1 for one cycle, exit_code_o=gpr3, done_o=1.
REQ-005 K=0x0002 (report): next cycle report_valid_o=1 for one cycle, report_data_o=gpr3; report_data_o holds until the next report.
REQ-006 K=0x0004 (putc): gpr3[7:0] SHALL be pushed into the FIFO, visible on char_valid_o/char_data_o the next cycle.
REQ-007 K=0x0005 (count reset): insn_cnt_o SHALL become 0 next cycle (this instruction not counted).
REQ-008 Any other K SHALL be treated as an ordinary instruction with no trap side effect.
REQ-009 insn_cnt_o SHALL increment by 1 per wb_valid cycle, wrap 0xFFFFFFFF->0, and not count count-reset traps.
REQ-010 FIFO pop SHALL occur when char_valid_o=1 and char_ready_i=1; char_data_o stable while char_valid_o=1 and not popped.
REQ-011 Push when full and no pop SHALL drop the character and set char_ovf_o; push and pop in the same cycle when full SHALL both succeed.
REQ-012 Push and pop in the same cycle with FIFO empty SHALL not bypass: char appears next cycle.
REQ-013 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with an extra pointer bit.
REQ-014 State machine RUN/DONE: RUN->DONE on exit trap; in DONE, traps, counting and watchdog are frozen; FIFO draining continues.
REQ-015 Watchdog: idle counter clears on wb_valid, increments otherwise; reaching WDT_CYCLES sets hang_o (sticky); frozen at 0 when WDT_CYCLES=0.
REQ-016 Only one trap per cycle possible; all outputs are registered with one-cycle latency from the trap.

Reset
REQ-017 rst_n low SHALL asynchronously clear: all pulses, done_o, char_ovf_o, hang_o, exit_code_o, report_data_o, insn_cnt_o, watchdog counter, FIFO pointers (char_valid_o=0, char_data_o=0), state=RUN.
REQ-018 Reset mid-operation SHALL discard FIFO contents and any trap sampled in the same cycle; normal operation resumes on first rising edge after rst_n high.

Verification
REQ-019 Retire 10 non-trap insns, then l.nop 5, then 3 insns -> insn_cnt_o 10, then 0, then 3.
REQ-020 putc 'H','i' with char_ready_i=0, then raise ready -> char_valid_o high, bytes 0x48 then 0x69 in order, then char_valid_o=0.
REQ-021 9 putc with ready=0, FIFO_DEPTH=8 -> 8 chars stored, char_ovf_o=1, 9th lost; push+pop when full -> count stays 8, no ovf change.
REQ-022 gpr3=0x0000002A, l.nop 1 -> exit_o one pulse, exit_code_o=0x2A, done_o=1; later report trap -> no report_valid_o, insn_cnt_o frozen.
REQ-023 WDT_CYCLES=16, no wb_valid for 16 cycles -> hang_o=1 and stays 1; wb_valid at cycle 15 -> hang_o stays 0.
REQ-024 Assert rst_n=0 mid-stream with 3 chars queued -> char_valid_o=0, insn_cnt_o=0 immediately, no clock edge required.
